// File: rtl/req_encoder_pkg.sv
// Shared sizes, FSM state encoding and helpers for the request encoder.
// Build option: define REQ_ENCODER_RR_EN for round-robin selection (default is fixed priority).
package req_encoder_pkg;

  localparam int unsigned NREQ = 16;
  localparam int unsigned AW   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

`ifdef REQ_ENCODER_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  // One-hot select line for a register address.
  function automatic logic [NREQ-1:0] onehot(input logic [AW-1:0] a);
    logic [NREQ-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/req_encoder_pick.sv
// Combinational picker: first set request at or after 'start', wrapping 15->0.
// Rotate right by start, priority-encode the lowest set bit, then add start back.
module req_encoder_pick
  import req_encoder_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [AW-1:0]   start,
  output logic [AW-1:0]   idx,
  output logic            any
);

  logic [NREQ-1:0] rot;
  logic [AW-1:0]   off;

  always_comb begin
    rot = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      rot[i] = req[AW'(i + int'(start))];
    end
  end

  // Scan downward so the lowest set bit is the one left standing.
  always_comb begin
    off = '0;
    for (int i = int'(NREQ) - 1; i >= 0; i--) begin
      if (rot[i]) off = AW'(i);
    end
  end

  assign idx = off + start;
  assign any = |req;

endmodule

// File: rtl/req_encoder.sv
// 16-line request encoder: grants one request as a 4-bit address, held until ack.
// Build option: REQ_ENCODER_RR_EN selects round-robin instead of fixed priority.
module req_encoder
  import req_encoder_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic [NREQ-1:0] req,
  input  logic            ack,
  output logic [AW-1:0]   addr,
  output logic [NREQ-1:0] grant,
  output logic            valid
);

  state_t        state;
  logic [AW-1:0] last;
  logic [AW-1:0] start;
  logic [AW-1:0] pick;
  logic          any;

  // Fixed priority keeps last up to date but always searches from index 0.
  assign start = RR_EN ? last + AW'(1) : '0;

  req_encoder_pick u_pick (
    .req  (req),
    .start(start),
    .idx  (pick),
    .any  (any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      addr  <= '0;
      grant <= '0;
      valid <= 1'b0;
      last  <= AW'(NREQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && any) begin
            addr  <= pick;
            grant <= onehot(pick);
            valid <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Grant is frozen here; only ack releases it.
          if (ack) begin
            valid <= 1'b0;
            grant <= '0;
            last  <= addr;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_encoder.sv
// Self-checking bench for req_encoder: directed table, hand sequences, random vs model.
module tb_req_encoder;

  logic        clk = 1'b0;
  logic        reset, enable, ack;
  logic [15:0] req;
  logic [3:0]  addr;
  logic [15:0] grant;
  logic        valid;

  always #5 clk = ~clk;

  req_encoder dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .req   (req),
    .ack   (ack),
    .addr  (addr),
    .grant (grant),
    .valid (valid)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: what the consumer should see, plus the last-acked index.
  bit mvalid;
  int maddr;
  int mlast;

  typedef struct {
    bit          rst;
    bit          en;
    logic [15:0] r;
    bit          ak;
    bit          ev;
    logic [3:0]  ea;
    logic [15:0] eg;
  } row_t;

  row_t tbl[$];

  function automatic int ref_pick(input logic [15:0] r, input int lst);
    int first;
    int i;
`ifdef REQ_ENCODER_RR_EN
    first = lst + 1;
`else
    first = 0;
`endif
    for (int k = 0; k < 16; k++) begin
      i = (first + k) % 16;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic v, input logic [3:0] a,
                       input logic [15:0] g);
    checks++;
    if (valid !== v || addr !== a || grant !== g) begin
      errors++;
      $display("FAIL %s @%0t: got valid=%0b addr=%h grant=%h, want valid=%0b addr=%h grant=%h",
               name, $time, valid, addr, grant, v, a, g);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare.
  task automatic tick(input string name);
    logic [15:0] eg;
    @(posedge clk);
    if (reset) begin
      mvalid = 1'b0;
      maddr  = 0;
      mlast  = 15;
    end else if (!mvalid) begin
      if (enable && req != 16'h0) begin
        maddr  = ref_pick(req, mlast);
        mvalid = 1'b1;
      end
    end else if (ack) begin
      mvalid = 1'b0;
      mlast  = maddr;
    end
    #1;
    eg = mvalid ? (16'h0001 << maddr) : 16'h0000;
    check(name, mvalid, 4'(maddr), eg);
  endtask

  task automatic drive(input bit rs, input bit en, input logic [15:0] r, input bit ak);
    reset  = rs;
    enable = en;
    req    = r;
    ack    = ak;
  endtask

  initial begin
    int exp_a;
    drive(1'b1, 1'b0, 16'h0, 1'b0);

    // Mode-independent directed rows: reset, idle, hold/reset, enable-low hold, stray ack.
    tbl.push_back('{1, 0, 16'h0000, 0, 0, 4'h0, 16'h0000});
    for (int i = 0; i < 10; i++) tbl.push_back('{0, 1, 16'h0000, 0, 0, 4'h0, 16'h0000});
    tbl.push_back('{0, 1, 16'h0080, 0, 1, 4'h7, 16'h0080});
    tbl.push_back('{0, 1, 16'hFFFF, 0, 1, 4'h7, 16'h0080});
    tbl.push_back('{1, 1, 16'hFFFF, 1, 0, 4'h0, 16'h0000});
    tbl.push_back('{0, 1, 16'h0080, 0, 1, 4'h7, 16'h0080});
    tbl.push_back('{0, 1, 16'h0080, 1, 0, 4'h7, 16'h0000});
    tbl.push_back('{0, 1, 16'h0000, 1, 0, 4'h7, 16'h0000});
    tbl.push_back('{0, 1, 16'h0000, 1, 0, 4'h7, 16'h0000});
    tbl.push_back('{0, 1, 16'h8000, 0, 1, 4'hF, 16'h8000});
    tbl.push_back('{0, 0, 16'h0000, 0, 1, 4'hF, 16'h8000});
    tbl.push_back('{0, 0, 16'h0000, 0, 1, 4'hF, 16'h8000});
    tbl.push_back('{0, 0, 16'h0000, 1, 0, 4'hF, 16'h0000});
    tbl.push_back('{0, 0, 16'hFFFF, 0, 0, 4'hF, 16'h0000});
    tbl.push_back('{0, 0, 16'hFFFF, 1, 0, 4'hF, 16'h0000});
    tbl.push_back('{0, 0, 16'hFFFF, 0, 0, 4'hF, 16'h0000});

    foreach (tbl[n]) begin
      drive(tbl[n].rst, tbl[n].en, tbl[n].r, tbl[n].ak);
      tick("model");
      check($sformatf("table[%0d]", n), tbl[n].ev, tbl[n].ea, tbl[n].eg);
    end

    // Two requests: first grant 5, second grant depends on the selection mode.
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    tick("model");
    drive(1'b0, 1'b1, 16'h0120, 1'b0);
    tick("model");
    check("two_req_first", 1'b1, 4'h5, 16'h0020);
    tick("model");
    tick("model");
    ack = 1'b1;
    tick("model");
    check("two_req_ack", 1'b0, 4'h5, 16'h0000);
    ack = 1'b0;
    tick("model");
`ifdef REQ_ENCODER_RR_EN
    check("two_req_second", 1'b1, 4'h8, 16'h0100);
`else
    check("two_req_second", 1'b1, 4'h5, 16'h0020);
`endif

    // All requests held, ack each grant: rotating addresses or always 0.
    drive(1'b1, 1'b0, 16'h0, 1'b0);
    tick("model");
    drive(1'b0, 1'b1, 16'hFFFF, 1'b0);
    tick("model");
    check("sweep_0", 1'b1, 4'h0, 16'h0001);
    for (int n = 1; n <= 16; n++) begin
      ack = 1'b1;
      tick("model");
      ack = 1'b0;
      tick("model");
`ifdef REQ_ENCODER_RR_EN
      exp_a = n % 16;
`else
      exp_a = 0;
`endif
      check($sformatf("sweep_%0d", n), 1'b1, 4'(exp_a), 16'h0001 << exp_a);
    end

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 63) == 0);
      enable = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       req = 16'h0000;
        1:       req = 16'h0001 << $urandom_range(0, 15);
        2:       req = 16'(($urandom & $urandom) & 32'hFFFF);
        default: req = 16'($urandom);
      endcase
      ack = $urandom_range(0, 1) == 1;
      tick("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
